// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// A byte moves when in_valid and in_ready are both 1 on a rising clk edge; a write happens on every cycle wr_en is 1.
`ifndef DataBusBits
`define DataBusBits 32
`endif
`ifndef InstrBusBits
`define InstrBusBits 32
`endif

interface imem_loader_if;
    logic [7:0]                 in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic                       wr_en;
    logic [`DataBusBits-1:0]    wr_addr;
    logic [`InstrBusBits-1:0]   wr_data;

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Streams bytes into 32-bit little-endian instruction words and writes them to consecutive
// word addresses of a 2^N-word instruction memory, keeping a running checksum.
`ifndef DataBusBits
`define DataBusBits 32
`endif
`ifndef InstrBusBits
`define InstrBusBits 32
`endif

module imem_loader #(
    parameter int N = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [`DataBusBits-1:0] base_addr,
    input  logic [N:0]              word_count,
    input  logic                    abort,
    imem_loader_if.slave            bus,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [31:0]             checksum,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [N:0]                  WORD_ONE  = 1;
    localparam logic [`DataBusBits-1:0]     ADDR_MASK = ~`DataBusBits'(3);
    localparam logic [`DataBusBits-1:0]     ADDR_STEP = `DataBusBits'(4);

    state_t                     state;
    state_t                     state_nx;
    logic [1:0]                 byte_idx;
    logic [N:0]                 word_cnt;
    logic [N:0]                 word_total;
    logic [`DataBusBits-1:0]    addr;
    logic [`InstrBusBits-1:0]   data;

    logic accept_start;
    logic accept_byte;
    logic leave_write;
    logic last_word;
    logic at_top;

    assign accept_start = (state == IDLE) && start;
    assign accept_byte  = (state == RECV) && bus.in_valid && !abort;
    assign leave_write  = (state == WRITE) && !abort;
    assign last_word    = (word_cnt + WORD_ONE) == word_total;
    // Word index of the current write is the highest in memory: one more would wrap.
    assign at_top       = &addr[N+1:2];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (word_count != '0) ? RECV : DONE;
                end
            end
            RECV: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (bus.in_valid && (byte_idx == 2'd3)) begin
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (last_word || at_top) begin
                    state_nx = DONE;
                end else begin
                    state_nx = RECV;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_idx   <= '0;
            word_cnt   <= '0;
            word_total <= '0;
            addr       <= '0;
            data       <= '0;
            checksum   <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept_start) begin
                byte_idx   <= '0;
                word_cnt   <= '0;
                checksum   <= '0;
                err        <= 1'b0;
                word_total <= word_count;
                addr       <= base_addr & ADDR_MASK;
            end
            if (accept_byte) begin
                data[{byte_idx, 3'b000} +: 8] <= bus.in_data;
                byte_idx                      <= byte_idx + 2'd1;
            end
            if (leave_write) begin
                checksum <= checksum + data;
                word_cnt <= word_cnt + WORD_ONE;
                // Out of memory with words still pending: flag it and hold the address.
                if (at_top && !last_word) begin
                    err <= 1'b1;
                end else begin
                    addr <= addr + ADDR_STEP;
                end
            end
        end
    end

    assign bus.in_ready = (state == RECV);
    assign bus.wr_en    = (state == WRITE) && !abort;
    assign bus.wr_addr  = addr;
    assign bus.wr_data  = data;
    assign busy         = (state == RECV) || (state == WRITE);
    assign done         = (state == DONE);
    assign dbg_state    = state;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a word-level model predicts every write, the checksum and err,
// and a per-cycle compare process checks each wr_en cycle against the expected write queue.
module tb_imem_loader;

    localparam int N  = 14;
    localparam int NS = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (default depth) ----------------
    logic        start;
    logic [31:0] base_addr;
    logic [N:0]  word_count;
    logic        abort;
    logic        busy, done, err;
    logic [31:0] checksum;
    logic [1:0]  dbg_state;

    imem_loader_if bif ();

    imem_loader #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .abort      (abort),
        .bus        (bif),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum),
        .dbg_state  (dbg_state)
    );

    // ---------------- DUT (tiny depth, top-of-memory case) ----------------
    logic        s_start;
    logic [31:0] s_base_addr;
    logic [NS:0] s_word_count;
    logic        s_abort;
    logic        s_busy, s_done, s_err;
    logic [31:0] s_checksum;
    logic [1:0]  s_dbg_state;

    imem_loader_if sif ();

    imem_loader #(.N(NS)) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (s_start),
        .base_addr  (s_base_addr),
        .word_count (s_word_count),
        .abort      (s_abort),
        .bus        (sif),
        .busy       (s_busy),
        .done       (s_done),
        .err        (s_err),
        .checksum   (s_checksum),
        .dbg_state  (s_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  src_q[$];
    int          s_writes = 0;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] e;
        #1;
        if (rst_n && bif.wr_en) begin
            chk("in_ready_during_write", {31'd0, bif.in_ready}, 32'd0);
            last_wr_addr = bif.wr_addr;
            last_wr_data = bif.wr_data;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write", bif.wr_addr, bif.wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", bif.wr_addr, e[63:32]);
                chk("wr_data", bif.wr_data, e[31:0]);
            end
        end
        if (rst_n && sif.wr_en) s_writes++;
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, output bit ok);
        int tries;
        tries = 0;
        bif.in_valid = 1'b1;
        bif.in_data  = b;
        while (!bif.in_ready && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (!bif.in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 20 cycles");
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        ok = 1'b1;
    endtask

    // One load. abort_bytes < 0: run to completion; otherwise abort after that many bytes.
    // Starts and ends at a falling edge.
    task automatic run_load(input logic [31:0] base, input int count, input int gap_pct, input int abort_bytes);
        logic [7:0]  b[$];
        logic [31:0] a;
        logic [31:0] word;
        logic [31:0] sum;
        int          room, nw, n_wr, n_send;
        bit          exp_err, ok;

        b.delete();
        for (int i = 0; i < 4 * count; i++) begin
            if (src_q.size() > 0) b.push_back(src_q.pop_front());
            else                  b.push_back(8'($urandom));
        end
        src_q.delete();

        // Word-level model: how many words fit above the start index, what gets written.
        a       = base & 32'hFFFF_FFFC;
        room    = (1 << N) - int'(a[N+1:2]);
        exp_err = (count > room);
        nw      = exp_err ? room : count;
        n_wr    = (abort_bytes < 0) ? nw : ((abort_bytes == 0) ? 0 : (abort_bytes - 1) / 4);
        sum     = 32'd0;
        for (int i = 0; i < nw; i++) begin
            word = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
            sum  = sum + word;
            if (i < n_wr) exp_q.push_back({a + 32'(4 * i), word});
        end

        start      = 1'b1;
        base_addr  = base;
        word_count = (N+1)'(count);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        #1;

        if (count == 0) begin
            chk("zero_done", {31'd0, done}, 32'd1);
            chk("zero_wr_en", {31'd0, bif.wr_en}, 32'd0);
            chk("zero_err", {31'd0, err}, 32'd0);
            @(negedge clk);
            #1;
            chk("zero_done_one_cycle", {31'd0, done}, 32'd0);
            return;
        end

        n_send = (abort_bytes < 0) ? 4 * nw : abort_bytes;
        for (int j = 0; j < n_send; j++) begin
            while ($urandom_range(99) < gap_pct) begin
                bif.in_valid = 1'b0;
                start        = 1'($urandom_range(1));
                base_addr    = $urandom;
                word_count   = (N+1)'($urandom);
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(b[j], ok);
            if (!ok) return;
        end
        bif.in_valid = 1'b0;

        if (abort_bytes >= 0) begin
            abort = 1'b1;
            @(posedge clk);
            @(negedge clk);
            abort = 1'b0;
            #1;
            chk("abort_busy", {31'd0, busy}, 32'd0);
            chk("abort_done", {31'd0, done}, 32'd0);
            chk("abort_pending_writes", 32'(exp_q.size()), 32'd0);
            @(negedge clk);
            #1;
            chk("abort_no_late_done", {31'd0, done}, 32'd0);
            return;
        end

        #1;
        chk("last_write_latency", {31'd0, bif.wr_en}, 32'd1);
        @(negedge clk);
        #1;
        chk("done_latency", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("checksum", checksum, sum);
        @(negedge clk);
        #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("checksum_hold", checksum, sum);
        chk("err_hold", {31'd0, err}, {31'd0, exp_err});
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0]  pat[$];
        logic [31:0] base;
        int          cnt, ab, room;
        bit          ok;

        start = 1'b0; base_addr = '0; word_count = '0; abort = 1'b0;
        bif.in_valid = 1'b0; bif.in_data = '0;
        s_start = 1'b0; s_base_addr = '0; s_word_count = '0; s_abort = 1'b0;
        sif.in_valid = 1'b0; sif.in_data = '0;

        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, bif.in_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, bif.wr_en}, 32'd0);
        chk("rst_wr_addr", bif.wr_addr, 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Known two-word program.
        src_q = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load(32'h0000_0100, 2, 0, -1);
        chk("prog_checksum", checksum, 32'h0010_00A6);
        chk("prog_last_addr", last_wr_addr, 32'h0000_0104);
        chk("prog_last_data", last_wr_data, 32'h0010_0093);

        // Empty load.
        run_load(32'h0000_0200, 0, 0, -1);

        // Same three words, gap-free then with random gaps.
        pat.delete();
        for (int i = 0; i < 12; i++) pat.push_back(8'($urandom));
        src_q = pat;
        run_load(32'h0000_0301, 3, 0, -1);
        src_q = pat;
        run_load(32'h0000_0301, 3, 50, -1);

        // Abort after two bytes of the first word, then a clean reload.
        run_load(32'h0000_0400, 2, 0, 2);
        run_load(32'h0000_0400, 2, 20, -1);

        // Reset pulsed between edges mid-word.
        start = 1'b1; base_addr = 32'h0000_0800; word_count = 1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        send_byte(8'hAA, ok);
        send_byte(8'hBB, ok);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_in_ready", {31'd0, bif.in_ready}, 32'd0);
        chk("midrst_wr_data", bif.wr_data, 32'd0);
        chk("midrst_wr_addr", bif.wr_addr, 32'd0);
        #1 rst_n = 1'b1;
        bif.in_valid = 1'b0;
        @(negedge clk);
        src_q = {8'h01, 8'h02, 8'h03, 8'h04};
        run_load(32'h0000_0800, 1, 0, -1);
        chk("midrst_reload_data", last_wr_data, 32'h0403_0201);

        // Top of a 16-word memory: one write at 0x3C, then err.
        s_start = 1'b1; s_base_addr = 32'h0000_003C; s_word_count = 2;
        @(posedge clk);
        @(negedge clk);
        s_start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            int tries;
            tries = 0;
            sif.in_valid = 1'b1;
            sif.in_data  = 8'(8'h11 * (j + 1));
            while (!sif.in_ready && tries < 20) begin
                @(negedge clk);
                tries++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        sif.in_data = 8'hEE;
        #1;
        chk("top_wr_en", {31'd0, sif.wr_en}, 32'd1);
        chk("top_wr_addr", sif.wr_addr, 32'h0000_003C);
        chk("top_wr_data", sif.wr_data, 32'h4433_2211);
        @(negedge clk);
        #1;
        chk("top_done", {31'd0, s_done}, 32'd1);
        chk("top_err", {31'd0, s_err}, 32'd1);
        chk("top_no_second_write", {31'd0, sif.wr_en}, 32'd0);
        @(negedge clk);
        sif.in_valid = 1'b0;
        @(negedge clk);
        chk("top_write_count", 32'(s_writes), 32'd1);
        chk("top_err_hold", {31'd0, s_err}, 32'd1);

        // Randomized loads, some near the top of memory, some aborted.
        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(3) == 0)
                base = (32'((1 << N) - $urandom_range(1, 3)) << 2) | 32'($urandom_range(3));
            else
                base = $urandom & 32'h0000_FFFF;
            cnt  = $urandom_range(0, 5);
            room = (1 << N) - int'(base[N+1:2]);
            ab   = -1;
            if (cnt > 0 && $urandom_range(4) == 0)
                ab = $urandom_range(0, 4 * ((cnt > room) ? room : cnt) - 1);
            run_load(base, cnt, $urandom_range(0, 60), ab);
        end

        chk("final_pending_writes", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter N, default 14, SHALL set the instruction memory depth in words (2^N).
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-004 Port start, input, 1, SHALL be a one-cycle load request, sampled only in IDLE.
REQ-005 Port base_addr, input, `DataBusBits, SHALL be the first byte address, sampled with start; bits [1:0] are ignored (treated as 0).
REQ-006 Port word_count, input, N+1, SHALL be the number of words to load, sampled with start.
REQ-007 Port abort, input, 1, SHALL be a synchronous cancel request.
REQ-008 Port in_data, input, 8, SHALL be the incoming byte.
REQ-009 Ports in_valid (input, 1) and in_ready (output, 1) SHALL form the byte handshake; a byte transfers when both are 1 on a rising edge.
REQ-010 Port wr_en, output, 1, SHALL be the instruction-memory write strobe.
REQ-011 Port wr_addr, output, `DataBusBits, SHALL be the word-aligned byte address of the write; bits [1:0] are always 0.
REQ-012 Port wr_data, output, `InstrBusBits, SHALL be the assembled instruction word.
REQ-013 Ports busy, done, err (outputs, 1 each) and checksum (output, 32) SHALL report status.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, RECV, WRITE, DONE.
REQ-015 IDLE: start=1 with word_count>0 -> RECV; start=1 with word_count=0 -> DONE; otherwise remain in IDLE.
REQ-016 On accepting start, the block SHALL clear the byte index, word counter, checksum and err, and latch word_count and base_addr with bits [1:0] forced to 0.
REQ-017 in_ready SHALL be 1 only in RECV and SHALL be combinational from state only, never from in_valid.
REQ-018 Bytes SHALL assemble little-endian: the first byte of each word lands in bits [7:0] and the fourth in bits [31:24].
REQ-019 On the fourth accepted byte of a word, the FSM SHALL go to WRITE; in_valid=0 cycles SHALL neither advance the index nor change state.
REQ-020 WRITE SHALL last exactly one cycle with wr_en=1; wr_data and wr_addr SHALL be stable and valid for that cycle; in_ready=0.
REQ-021 Leaving WRITE, the block SHALL add wr_data to checksum modulo 2^32, increment the word counter, and advance wr_addr by 4.
REQ-022 Leaving WRITE with the word counter equal to word_count SHALL go to DONE; otherwise the FSM SHALL return to RECV.
REQ-023 If wr_addr[N+1:2] was all ones when leaving WRITE and words remain, err SHALL be set and the FSM SHALL go to DONE; the address SHALL never wrap.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-025 Latency SHALL be: last byte accepted at edge k -> wr_en high in cycle k+1 -> done high in cycle k+2.
REQ-026 busy SHALL be 1 in RECV and WRITE and 0 in IDLE and DONE.
REQ-027 abort=1 in RECV or WRITE SHALL go to IDLE next edge, discard the partial word, and suppress wr_en in that cycle and done; abort has priority over byte acceptance.
REQ-028 start while busy, and abort in IDLE or DONE, SHALL be ignored.
REQ-029 err and checksum SHALL hold their values until the next accepted start.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE and set in_ready, wr_en, busy, done and err to 0, and wr_addr, wr_data and checksum to 0, regardless of clk.
REQ-031 Reset asserted mid-load SHALL discard all progress; no write SHALL occur after reset is released until a new start is accepted.

Verification
REQ-032 base_addr=0x100, word_count=2, bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013@0x100 and 0x00100093@0x104, done 1 cycle, checksum 0x001000A6.
REQ-033 start with word_count=0 -> done=1 the next cycle, no wr_en, err=0.
REQ-034 Random in_valid gaps on a 3-word load -> identical writes to a gap-free load; in_ready never 1 during WRITE.
REQ-035 abort after 2 bytes of word 1 -> no wr_en, no done, busy=0 next cycle; a new start then loads correctly.
REQ-036 N=4, base_addr=0x3C, word_count=2 -> one write @0x3C, then err=1 and done=1, no second write.
REQ-037 rst_n pulsed low between clock edges mid-word -> outputs 0 immediately, and the subsequent load starts at byte index 0.
